// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Holds the controller state encoding and the default operand width.
package serial_add_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_ha.sv
// Structural 1-bit full adder built from two half adders.
// Ports: a, b, cin in; s (sum bit), co (carry out) out.
module fa_ha (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic hs;
   logic hc0;
   logic hc1;

   xor u_x0 (hs, a, b);
   and u_a0 (hc0, a, b);
   xor u_x1 (s, hs, cin);
   and u_a1 (hc1, hs, cin);
   or  u_o0 (co, hc0, hc1);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one fa_ha cell walks WIDTH-bit operands
// LSB first, one bit per clock, between two valid/ready handshakes.
// Ports: clk, rst (async, active-high);
//   start_valid/start_ready with a, b, cin (operand request);
//   res_valid/res_ready with sum, cout, ovf (result); busy (RUN or DONE).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             cim_q, cim_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_s;
   logic fa_co;

   fa_ha u_fa (
      .a   (a_sh_q[0]),
      .b   (b_sh_q[0]),
      .cin (carry_q),
      .s   (fa_s),
      .co  (fa_co)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      count_d  = count_q;
      carry_d  = carry_q;
      cim_d    = cim_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_co;
            count_d  = count_q + CNT_W'(1);
            // carry out of bit WIDTH-2 is the carry into the MSB
            if (count_q == CNT_W'(WIDTH - 2))
               cim_d = fa_co;
            if (count_q == CNT_W'(WIDTH - 1)) begin
               cout_d  = fa_co;
               ovf_d   = cim_q ^ fa_co;
               count_d = count_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         count_q  <= '0;
         carry_q  <= 1'b0;
         cim_q    <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         count_q  <= count_d;
         carry_q  <= carry_d;
         cim_q    <= cim_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign start_ready = (state_q == S_IDLE);
   assign res_valid   = (state_q == S_DONE);
   assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
   assign sum         = sum_sh_q;
   assign cout        = cout_q;
   assign ovf         = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: time-multiplexes one 1-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock.
- Trades latency for area in the arithmetic datapath.
- Accepts operand pairs on a valid/ready handshake and returns sum, carry-out and signed overflow on a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  operand request valid.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled on start handshake.
- b  input  WIDTH  operand B, sampled on start handshake.
- cin  input  1  carry-in, sampled on start handshake.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into MSB XOR cout.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. rst=1 immediately forces:
  - state=IDLE;
  - a_sh, b_sh, sum_sh, count, carry, cout, ovf all 0;
  - start_ready=1, res_valid=0, busy=0, sum=0.
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready at edge k:
    - a_sh<=a, b_sh<=b, carry<=cin, count<=0;
    - go to RUN.
  - RUN: each edge:
    - fa cell computes s,co from a_sh[0], b_sh[0], carry;
    - sum_sh<={s,sum_sh[WIDTH-1:1]};
    - a_sh and b_sh shift right by 1;
    - carry<=co, count<=count+1.
    - When count==WIDTH-2, latch carry_in_msb<=co.
    - When count==WIDTH-1, latch cout<=co and ovf<=carry_in_msb^co, then go to DONE.
  - DONE: res_valid=1; sum, cout and ovf stable. On res_valid&&res_ready, go to IDLE.
- Latency: start handshake at edge k, then res_valid high after edge k+WIDTH.
- Throughput: one result per WIDTH+2 cycles with res_ready tied high. There is one IDLE cycle between operations; no overlap of accept and result.
- start_ready is combinational from state (state==IDLE) only, never from start_valid.
- res_valid is registered state (DONE). Once asserted, it holds with stable data until accepted.
- start_valid during RUN/DONE is ignored; a, b and cin may change freely outside the handshake edge.
- sum is driven directly from sum_sh. It is meaningful only while res_valid=1 and holds its last value in IDLE until the next RUN overwrites it.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the unsigned carry; ovf is the two's-complement overflow.
- Reset mid-RUN or mid-DONE aborts the operation without producing a result. The first legal handshake is the first rising edge after rst deasserts.
- count never exceeds WIDTH-1; no wrap occurs.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH.
- Illegal state 2'd3 recovers to S_IDLE on the next edge.
- One sub-module instance: the team's existing structural full adder fa_ha as the single 1-bit cell (a, b, cin, s, co). The controller holds all registers; no second adder instance.

Test Plan (WIDTH=8):
- a=0x5A, b=0x33, cin=0, res_ready=1 -> res_valid exactly 8 cycles after accept; sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Separately, a=0x7F, b=0x80, cin=1 -> sum=0x00, cout=1, ovf=0.
- Backpressure: a=0x10, b=0x20, res_ready held 0 for 5 cycles after res_valid -> sum=0x30, cout=0 stable for all 5 cycles. start_ready=0 throughout, and a concurrent start_valid is ignored.
- Back-to-back: start_valid held 1 with res_ready=1 -> accepts 10 cycles apart; second result (0x01+0x01) = 0x02, uncorrupted by the first.
- Reset mid-operation: assert rst 3 cycles into RUN -> outputs zero immediately, start_ready=1, no res_valid. A fresh request after release completes normally.
- Exhaustive random: 1000 random a, b, cin pairs checked against a reference model of {cout,sum}=a+b+cin and ovf=(a[7]==b[7])&&(sum[7]!=a[7]).
